voice_mixer: RTL and testbench

Parametrised successor to the fixed four-voice wrap-around adder at the synth top level. It snapshots NUM_VOICES voice samples on each sample tick and accumulates them time-multiplexed, one voice per Clk cycle, with per-voice enable and gain. It then applies master volume and saturates to a SAMPLE_W audio word for the audio interface. It sits between the Voice instances and audio_interface LDATA/RDATA, with gains driven from soc PIO registers.

---
 rtl/voice_mixer_pkg.sv | 25 ++
 rtl/voice_mixer_saturate.sv | 29 ++
 rtl/voice_mixer.sv | 143 ++++++++++++++
 tb/tb_voice_mixer.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/voice_mixer_pkg.sv
// voice_mixer_pkg
//   Shared types and sizing helpers for the voice mixer slice.
//   mix_state_t : sequencer states (IDLE, ACCUM, SCALE)
//   acc_width   : accumulator width that cannot wrap for a given voice count
//   unity_gain  : gain code that represents x1.0 for a GAIN_W-bit gain
package voice_mixer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        SCALE = 2'd2
    } mix_state_t;

    // One extra bit for the single-voice case keeps the product headroom
    // (signed sample times a zero-extended gain needs SAMPLE_W+GAIN_W+1 bits).
    function automatic int acc_width(input int sample_w, input int gain_w,
                                     input int num_voices);
        return sample_w + gain_w + $clog2(num_voices) + ((num_voices == 1) ? 1 : 0);
    endfunction

    function automatic int unity_gain(input int gain_w);
        return 1 << (gain_w - 1);
    endfunction

endpackage

// File: rtl/voice_mixer_saturate.sv
// mix_saturate
//   Combinational signed saturation from IN_W bits down to OUT_W bits.
//   in_val  : signed input word (IN_W > OUT_W)
//   out_val : input clamped to [-2^(OUT_W-1), 2^(OUT_W-1)-1]
//   sat     : 1 when clamping changed the value
module mix_saturate #(
    parameter int IN_W  = 32,
    parameter int OUT_W = 16
) (
    input  logic [IN_W-1:0]  in_val,
    output logic [OUT_W-1:0] out_val,
    output logic             sat
);

    // The value fits when every bit from the output sign bit upward agrees.
    logic [IN_W-OUT_W:0] top_bits;

    always_comb begin
        top_bits = in_val[IN_W-1:OUT_W-1];
        sat      = !((&top_bits) || (~|top_bits));
        if (sat) begin
            out_val = in_val[IN_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                                     : {1'b0, {(OUT_W-1){1'b1}}};
        end else begin
            out_val = in_val[OUT_W-1:0];
        end
    end

endmodule

// File: rtl/voice_mixer.sv
// voice_mixer
//   Snapshots NUM_VOICES samples on sample_tick, accumulates one voice per
//   cycle with per-voice enable and gain, applies master gain and saturates.
//   Clk, Reset   : clock, synchronous active-high reset
//   sample_tick  : one-cycle strobe per sample period
//   voice_data   : packed signed samples, voice i at [i*SAMPLE_W +: SAMPLE_W]
//   voice_en     : per-voice enable
//   voice_gain   : packed unsigned per-voice gains (unity = 2^(GAIN_W-1))
//   master_gain  : unsigned master volume
//   mix_out      : saturated mix, held between samples
//   mix_valid    : one-cycle pulse when mix_out updates
//   clip         : mix_out was saturated
//   overrun      : sticky, a tick arrived while busy
//   busy         : high in ACCUM and SCALE
module voice_mixer
    import voice_mixer_pkg::*;
#(
    parameter int NUM_VOICES = 8,
    parameter int SAMPLE_W   = 16,
    parameter int GAIN_W     = 8
) (
    input  logic                           Clk,
    input  logic                           Reset,
    input  logic                           sample_tick,
    input  logic [NUM_VOICES*SAMPLE_W-1:0] voice_data,
    input  logic [NUM_VOICES-1:0]          voice_en,
    input  logic [NUM_VOICES*GAIN_W-1:0]   voice_gain,
    input  logic [GAIN_W-1:0]              master_gain,
    output logic [SAMPLE_W-1:0]            mix_out,
    output logic                           mix_valid,
    output logic                           clip,
    output logic                           overrun,
    output logic                           busy
);

    localparam int ACC_W = acc_width(SAMPLE_W, GAIN_W, NUM_VOICES);
    localparam int SCL_W = ACC_W + GAIN_W + 1;
    localparam int SHIFT = 2 * (GAIN_W - 1);
    localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

    mix_state_t                     state;
    logic [IDX_W-1:0]               idx;
    logic signed [ACC_W-1:0]        acc;
    logic signed [SCL_W-1:0]        scaled_q;
    logic                           out_pending;

    logic [NUM_VOICES*SAMPLE_W-1:0] snap_data;
    logic [NUM_VOICES-1:0]          snap_en;
    logic [NUM_VOICES*GAIN_W-1:0]   snap_gain;
    logic [GAIN_W-1:0]              snap_master;

    logic [SAMPLE_W-1:0]            cur_data;
    logic [GAIN_W-1:0]              cur_gain;
    logic signed [ACC_W-1:0]        term;
    logic signed [SCL_W-1:0]        scaled_full;
    logic [SAMPLE_W-1:0]            sat_out;
    logic                           sat_flag;

    always_comb begin
        cur_data = snap_data[int'(idx)*SAMPLE_W +: SAMPLE_W];
        cur_gain = snap_gain[int'(idx)*GAIN_W +: GAIN_W];
        term     = '0;
        if (snap_en[idx]) begin
            term = ACC_W'($signed(cur_data)) * ACC_W'($signed({1'b0, cur_gain}));
        end
        // Arithmetic shift of the signed product floors toward -inf.
        scaled_full = (SCL_W'(acc) * SCL_W'($signed({1'b0, snap_master}))) >>> SHIFT;
    end

    mix_saturate #(
        .IN_W  (SCL_W),
        .OUT_W (SAMPLE_W)
    ) u_sat (
        .in_val  (scaled_q),
        .out_val (sat_out),
        .sat     (sat_flag)
    );

    // SCALE registers the master-gain product; saturation and the output
    // update happen on the following edge so the wide multiply and the clamp
    // sit in separate register stages (result lands NUM_VOICES+2 edges after
    // the tick). busy drops with SCALE, so the next tick may overlap that
    // final output stage without disturbing it.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state       <= IDLE;
            idx         <= '0;
            acc         <= '0;
            scaled_q    <= '0;
            out_pending <= 1'b0;
            snap_data   <= '0;
            snap_en     <= '0;
            snap_gain   <= '0;
            snap_master <= '0;
            mix_out     <= '0;
            mix_valid   <= 1'b0;
            clip        <= 1'b0;
            overrun     <= 1'b0;
            busy        <= 1'b0;
        end else begin
            mix_valid <= 1'b0;
            if (out_pending) begin
                mix_out     <= sat_out;
                clip        <= sat_flag;
                mix_valid   <= 1'b1;
                out_pending <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (sample_tick) begin
                        snap_data   <= voice_data;
                        snap_en     <= voice_en;
                        snap_gain   <= voice_gain;
                        snap_master <= master_gain;
                        acc         <= '0;
                        idx         <= '0;
                        busy        <= 1'b1;
                        state       <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (sample_tick) overrun <= 1'b1;
                    acc <= acc + term;
                    if (idx == IDX_W'(NUM_VOICES - 1)) begin
                        state <= SCALE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                SCALE: begin
                    if (sample_tick) overrun <= 1'b1;
                    scaled_q    <= scaled_full;
                    out_pending <= 1'b1;
                    busy        <= 1'b0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_voice_mixer.sv
module tb_voice_mixer;
    import voice_mixer_pkg::*;

    localparam int S = 16;
    localparam int G = 8;

    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic Reset;
    logic [G-1:0] master;

    logic               tick1, tick8, tick16;
    logic [1*S-1:0]     data1;
    logic [8*S-1:0]     data8;
    logic [16*S-1:0]    data16;
    logic [0:0]         en1;
    logic [7:0]         en8;
    logic [15:0]        en16;
    logic [1*G-1:0]     gain1;
    logic [8*G-1:0]     gain8;
    logic [16*G-1:0]    gain16;
    logic signed [S-1:0] out1, out8, out16;
    logic valid1, valid8, valid16, clip1, clip8, clip16;
    logic ovr1, ovr8, ovr16, busy1, busy8, busy16;

    voice_mixer #(.NUM_VOICES(8), .SAMPLE_W(S), .GAIN_W(G)) dut (
        .Clk(Clk), .Reset(Reset), .sample_tick(tick8), .voice_data(data8),
        .voice_en(en8), .voice_gain(gain8), .master_gain(master),
        .mix_out(out8), .mix_valid(valid8), .clip(clip8), .overrun(ovr8), .busy(busy8));

    voice_mixer #(.NUM_VOICES(1), .SAMPLE_W(S), .GAIN_W(G)) dut1 (
        .Clk(Clk), .Reset(Reset), .sample_tick(tick1), .voice_data(data1),
        .voice_en(en1), .voice_gain(gain1), .master_gain(master),
        .mix_out(out1), .mix_valid(valid1), .clip(clip1), .overrun(ovr1), .busy(busy1));

    voice_mixer #(.NUM_VOICES(16), .SAMPLE_W(S), .GAIN_W(G)) dut16 (
        .Clk(Clk), .Reset(Reset), .sample_tick(tick16), .voice_data(data16),
        .voice_en(en16), .voice_gain(gain16), .master_gain(master),
        .mix_out(out16), .mix_valid(valid16), .clip(clip16), .overrun(ovr16), .busy(busy16));

    int vectors = 0;
    int miscompares = 0;

    // Voice settings shared by all three instances; each sees its first n voices.
    int vd[16];
    int vg[16];
    bit ve[16];
    int vm;

    typedef struct {
        string    name;
        int       d[4];
        int       g0;
        int       gr;
        bit [7:0] en;
        int       mg;
        int       exp_out;
        bit       exp_clip;
    } vec_t;

    vec_t tbl[10];

    task automatic check(input string name, input longint act, input longint exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input string name, input int d0, input int d1,
                                input int d2, input int d3, input int g0, input int gr,
                                input bit [7:0] en, input int mg, input int eo, input bit ec);
        vec_t v;
        v.name = name;
        v.d[0] = d0; v.d[1] = d1; v.d[2] = d2; v.d[3] = d3;
        v.g0 = g0; v.gr = gr; v.en = en; v.mg = mg;
        v.exp_out = eo; v.exp_clip = ec;
        return v;
    endfunction

    task automatic drive();
        master = vm[G-1:0];
        data1  = vd[0][S-1:0];
        gain1  = vg[0][G-1:0];
        en1    = ve[0];
        for (int i = 0; i < 8; i++) begin
            data8[i*S +: S] = vd[i][S-1:0];
            gain8[i*G +: G] = vg[i][G-1:0];
            en8[i]          = ve[i];
        end
        for (int i = 0; i < 16; i++) begin
            data16[i*S +: S] = vd[i][S-1:0];
            gain16[i*G +: G] = vg[i][G-1:0];
            en16[i]          = ve[i];
        end
    endtask

    task automatic apply_vec(input vec_t v);
        for (int i = 0; i < 16; i++) begin
            vd[i] = (i < 4) ? v.d[i] : 7777;
            vg[i] = (i == 0) ? v.g0 : v.gr;
            ve[i] = (i < 8) ? v.en[i] : 1'b0;
        end
        vm = v.mg;
        drive();
    endtask

    // Reference: exact integer mix, floor division by unity^2, then clamp.
    function automatic void model(input int n, output int o, output bit c);
        longint acc, p, q, den;
        acc = 0;
        for (int i = 0; i < n; i++)
            if (ve[i]) acc += longint'(vd[i]) * longint'(vg[i]);
        den = longint'(unity_gain(G)) * longint'(unity_gain(G));
        p = acc * longint'(vm);
        q = p / den;
        if (p < 0 && q * den != p) q = q - 1;
        c = 1'b0;
        if (q > 32767)       begin q = 32767;  c = 1'b1; end
        else if (q < -32768) begin q = -32768; c = 1'b1; end
        o = int'(q);
    endfunction

    task automatic set_tick(input int n, input logic v);
        case (n)
            1:       tick1  = v;
            8:       tick8  = v;
            default: tick16 = v;
        endcase
    endtask

    function automatic logic get_valid(input int n);
        case (n) 1: return valid1; 8: return valid8; default: return valid16; endcase
    endfunction
    function automatic logic get_busy(input int n);
        case (n) 1: return busy1; 8: return busy8; default: return busy16; endcase
    endfunction
    function automatic logic get_clip(input int n);
        case (n) 1: return clip1; 8: return clip8; default: return clip16; endcase
    endfunction
    function automatic int get_out(input int n);
        case (n) 1: return int'(out1); 8: return int'(out8); default: return int'(out16); endcase
    endfunction

    // Returns just after the edge that sampled the tick (edge 0).
    task automatic pulse_tick(input int n);
        @(negedge Clk); set_tick(n, 1'b1);
        @(negedge Clk); set_tick(n, 1'b0);
    endtask

    // lat = edge number of the first mix_valid after edge 0, -1 on timeout.
    task automatic wait_valid(input int n, output int lat, output int bcnt);
        lat  = -1;
        bcnt = int'(get_busy(n));
        for (int k = 1; k <= 60; k++) begin
            @(negedge Clk);
            if (get_valid(n)) begin
                lat = k;
                break;
            end
            bcnt += int'(get_busy(n));
        end
    endtask

    task automatic count_valids(input int cycles, output int cnt, output int last_out);
        cnt = 0;
        last_out = 0;
        for (int k = 0; k < cycles; k++) begin
            @(negedge Clk);
            if (valid8) begin
                cnt++;
                last_out = int'(out8);
            end
        end
    endtask

    task automatic do_reset();
        @(negedge Clk); Reset = 1'b1;
        @(negedge Clk); Reset = 1'b0;
    endtask

    initial begin
        int lat, bcnt, o, cnt, exp_o;
        bit c;

        Reset = 1'b1;
        tick1 = 1'b0; tick8 = 1'b0; tick16 = 1'b0;
        for (int i = 0; i < 16; i++) begin vd[i] = 0; vg[i] = 128; ve[i] = 1'b0; end
        vm = 128;
        drive();
        repeat (3) @(negedge Clk);
        Reset = 1'b0;

        check("reset_mix_out", int'(out8), 0);
        check("reset_valid",   valid8, 0);
        check("reset_clip",    clip8, 0);
        check("reset_overrun", ovr8, 0);
        check("reset_busy",    busy8, 0);

        tbl[0] = mk("single_unity",   1000,     0,     0,     0, 128, 128, 8'h01, 128,   1000, 0);
        tbl[1] = mk("pos_saturate",  30000, 30000, 30000, 30000, 128, 128, 8'h0F, 128,  32767, 1);
        tbl[2] = mk("neg_saturate", -30000,-30000,-30000,-30000, 128, 128, 8'h0F, 128, -32768, 1);
        tbl[3] = mk("floor_half",     1000, -1001,     0,     0,  64,  64, 8'h03, 128,     -1, 0);
        tbl[4] = mk("v1_disabled",    1000, -1001,     0,     0,  64,  64, 8'h01, 128,    500, 0);
        tbl[5] = mk("master_zero",   30000, 30000, 30000, 30000, 128, 128, 8'h0F,   0,      0, 0);
        tbl[6] = mk("all_disabled",  30000, 30000, 30000, 30000, 128, 128, 8'h00, 128,      0, 0);
        tbl[7] = mk("max_gain",        100,     0,     0,     0, 255, 128, 8'h01, 255,    396, 0);
        tbl[8] = mk("upper_enables",  1000,     0,     0,     0, 128, 128, 8'hF1, 128,  32108, 0);
        tbl[9] = mk("neg_fullscale",-32768,     0,     0,     0, 128, 128, 8'h01, 128, -32768, 0);

        for (int t = 0; t < 10; t++) begin
            apply_vec(tbl[t]);
            pulse_tick(8);
            wait_valid(8, lat, bcnt);
            check({tbl[t].name, "_latency"}, lat, 10);
            check({tbl[t].name, "_out"}, int'(out8), tbl[t].exp_out);
            check({tbl[t].name, "_clip"}, clip8, tbl[t].exp_clip);
            if (t == 0) check("busy_cycles", bcnt, 9);
            @(negedge Clk);
            check({tbl[t].name, "_valid_one_cycle"}, valid8, 0);
        end
        check("no_overrun_yet", ovr8, 0);

        // Inputs changed right after the tick must not reach this sample.
        apply_vec(tbl[0]);
        pulse_tick(8);
        vd[0] = 5000; vg[0] = 255; vm = 255;
        drive();
        wait_valid(8, lat, bcnt);
        check("snapshot_out", int'(out8), 1000);

        // Second tick 3 cycles after the first.
        apply_vec(tbl[0]);
        pulse_tick(8);
        repeat (2) @(negedge Clk);
        tick8 = 1'b1;
        @(negedge Clk);
        tick8 = 1'b0;
        count_valids(25, cnt, o);
        check("overrun_valid_count", cnt, 1);
        check("overrun_first_result", o, 1000);
        check("overrun_set", ovr8, 1);
        apply_vec(tbl[4]);
        pulse_tick(8);
        wait_valid(8, lat, bcnt);
        check("overrun_next_out", int'(out8), 500);
        check("overrun_sticky", ovr8, 1);

        // Reset 4 cycles into ACCUM: everything clears, no result appears.
        apply_vec(tbl[1]);
        pulse_tick(8);
        repeat (4) @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        check("midreset_out",     int'(out8), 0);
        check("midreset_clip",    clip8, 0);
        check("midreset_overrun", ovr8, 0);
        check("midreset_busy",    busy8, 0);
        check("midreset_valid",   valid8, 0);
        count_valids(20, cnt, o);
        check("midreset_no_valid", cnt, 0);
        apply_vec(tbl[3]);
        pulse_tick(8);
        wait_valid(8, lat, bcnt);
        check("after_reset_out", int'(out8), -1);

        // Tick on the edge where SCALE returns to IDLE is still busy.
        do_reset();
        apply_vec(tbl[0]);
        pulse_tick(8);
        repeat (8) @(negedge Clk);
        tick8 = 1'b1;
        @(negedge Clk);
        tick8 = 1'b0;
        count_valids(25, cnt, o);
        check("scale_tick_valids", cnt, 1);
        check("scale_tick_overrun", ovr8, 1);

        // One edge later the tick is accepted: back-to-back at N+2 spacing.
        do_reset();
        apply_vec(tbl[0]);
        pulse_tick(8);
        repeat (9) @(negedge Clk);
        tick8 = 1'b1;
        @(negedge Clk);
        tick8 = 1'b0;
        cnt = int'(valid8);
        begin
            int c2;
            count_valids(25, c2, o);
            cnt += c2;
        end
        check("b2b_valids", cnt, 2);
        check("b2b_second_out", o, 1000);
        check("b2b_overrun", ovr8, 0);

        // Random regressions for 1, 8 and 16 voices against the model.
        for (int r = 0; r < 3; r++) begin
            int n;
            n = (r == 0) ? 1 : ((r == 1) ? 8 : 16);
            for (int s = 0; s < 20; s++) begin
                for (int i = 0; i < 16; i++) begin
                    vd[i] = int'($urandom_range(0, 65535)) - 32768;
                    if ($urandom_range(0, 1) == 1) vd[i] = vd[i] / 16;
                    vg[i] = int'($urandom_range(0, 255));
                    ve[i] = ($urandom_range(0, 3) != 0);
                end
                vm = int'($urandom_range(0, 255));
                drive();
                model(n, exp_o, c);
                pulse_tick(n);
                wait_valid(n, lat, bcnt);
                check($sformatf("rand_n%0d_latency", n), lat, n + 2);
                check($sformatf("rand_n%0d_out", n), get_out(n), exp_o);
                check($sformatf("rand_n%0d_clip", n), get_clip(n), c);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
